// File: rtl/ds_nn_search.sv
// Nearest-neighbour search: accumulates per-feature squared differences into one
// distance per training sample and tracks the minimum-distance sample and its label.
module ds_nn_search #(
    parameter int ACC_W = 20,
    parameter int IDX_W = 8,
    parameter int LBL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ds_valid,
    input  logic [15:0]      ds_result,
    input  logic             ds_last,
    input  logic             ds_final,
    input  logic [LBL_W-1:0] ds_label,
    output logic             busy,
    output logic             dist_valid,
    output logic [ACC_W-1:0] dist_sum,
    output logic [ACC_W-1:0] best_dist,
    output logic [IDX_W-1:0] best_idx,
    output logic [LBL_W-1:0] best_label,
    output logic             done,
    output logic             idx_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc_p0;
    logic [IDX_W-1:0] cnt_p0;
    logic [ACC_W-1:0] sum_p0;
    logic             beat;
    logic             beat_last;

    // Zero-extended add clamped to the accumulator's full-scale value.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [15:0]      b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // A start in the same cycle always wins over a data beat.
    assign beat      = (state == ACCUM) && ds_valid && !start;
    assign beat_last = beat && ds_last;
    assign sum_p0    = sat_add(acc_p0, ds_result);
    assign busy      = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (beat_last && ds_final) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Stage p0 -> outputs: sample completion, running minimum and search status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0     <= '0;
            cnt_p0     <= '0;
            dist_valid <= 1'b0;
            dist_sum   <= '0;
            best_dist  <= '1;
            best_idx   <= '0;
            best_label <= '0;
            done       <= 1'b0;
            idx_ovf    <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            if (start) begin
                acc_p0     <= '0;
                cnt_p0     <= '0;
                best_dist  <= '1;
                best_idx   <= '0;
                best_label <= '0;
                done       <= 1'b0;
                idx_ovf    <= 1'b0;
            end else if (beat_last) begin
                dist_sum   <= sum_p0;
                dist_valid <= 1'b1;
                acc_p0     <= '0;
                cnt_p0     <= cnt_p0 + IDX_W'(1);
                if (&cnt_p0) idx_ovf <= 1'b1;
                // Strict compare so a tie keeps the earlier sample.
                if (sum_p0 < best_dist) begin
                    best_dist  <= sum_p0;
                    best_idx   <= cnt_p0;
                    best_label <= ds_label;
                end
                if (ds_final) done <= 1'b1;
            end else if (beat) begin
                acc_p0 <= sum_p0;
            end
        end
    end

endmodule

// File: tb/tb_ds_nn_search.sv
// Randomized bench for ds_nn_search against a list-based nearest-sample model.
module tb_ds_nn_search;

    localparam int  ACC_W   = 20;
    localparam int  IDX_W   = 8;
    localparam int  LBL_W   = 2;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ds_valid = 1'b0;
    logic [15:0]      ds_result = '0;
    logic             ds_last = 1'b0;
    logic             ds_final = 1'b0;
    logic [LBL_W-1:0] ds_label = '0;

    logic             busy, dist_valid, done, idx_ovf;
    logic [ACC_W-1:0] dist_sum, best_dist;
    logic [IDX_W-1:0] best_idx;
    logic [LBL_W-1:0] best_label;

    logic             s_busy, s_dist_valid, s_done, s_idx_ovf;
    logic [ACC_W-1:0] s_dist_sum, s_best_dist;
    logic [1:0]       s_best_idx;
    logic [LBL_W-1:0] s_best_label;

    ds_nn_search #(.ACC_W(ACC_W), .IDX_W(IDX_W), .LBL_W(LBL_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ds_valid(ds_valid),
        .ds_result(ds_result), .ds_last(ds_last), .ds_final(ds_final),
        .ds_label(ds_label), .busy(busy), .dist_valid(dist_valid),
        .dist_sum(dist_sum), .best_dist(best_dist), .best_idx(best_idx),
        .best_label(best_label), .done(done), .idx_ovf(idx_ovf)
    );

    // Narrow-index copy on the same stimulus, used for the index overflow flag.
    ds_nn_search #(.ACC_W(ACC_W), .IDX_W(2), .LBL_W(LBL_W)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .ds_valid(ds_valid),
        .ds_result(ds_result), .ds_last(ds_last), .ds_final(ds_final),
        .ds_label(ds_label), .busy(s_busy), .dist_valid(s_dist_valid),
        .dist_sum(s_dist_sum), .best_dist(s_best_dist), .best_idx(s_best_idx),
        .best_label(s_best_label), .done(s_done), .idx_ovf(s_idx_ovf)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    longint exp_q[$];
    longint dists[$];
    int     lbls[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every dist_valid pulse must match the next expected completed sample.
    always @(negedge clk) begin
        if (rst_n && dist_valid === 1'b1) begin
            if (exp_q.size() == 0) check_val("dist_valid_unexpected", 1, 0);
            else check_val("dist_sum", 64'(dist_sum), 64'(exp_q.pop_front()));
        end
    end

    task automatic drive(input int v, input int r, input int l, input int f, input int lb);
        @(negedge clk);
        ds_valid  = v[0];
        ds_result = r[15:0];
        ds_last   = l[0];
        ds_final  = f[0];
        ds_label  = lb[LBL_W-1:0];
    endtask

    task automatic gap();
        drive(0, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic send_sample(input int nfeat, input int val, input int lbl,
                               input int fin, input int gap_pct);
        longint tot = 0;
        for (int f = 0; f < nfeat; f++) begin
            int v;
            v = (val < 0) ? int'($urandom_range(0, 65535)) : val;
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) gap();
            tot += v;
            if (f == nfeat - 1) begin
                exp_q.push_back(tot > ACC_MAX ? ACC_MAX : tot);
                dists.push_back(tot > ACC_MAX ? ACC_MAX : tot);
                lbls.push_back(lbl);
                drive(1, v, 1, fin, lbl);
            end else begin
                drive(1, v, 0, int'($urandom_range(0, 1)), int'($urandom));
            end
        end
        drive(0, 0, 0, 0, 0);
        check_val("dist_valid_latency", 64'(dist_valid), 1);
    endtask

    task automatic do_start(input int with_beat);
        @(negedge clk);
        start    = 1'b1;
        ds_valid = with_beat[0];
        ds_result = 16'd777;
        ds_last  = 1'b1;
        ds_final = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ds_valid = 1'b0;
        ds_last  = 1'b0;
        ds_final = 1'b0;
        dists.delete();
        lbls.delete();
        check_val("start_busy", 64'(busy), 1);
        check_val("start_done", 64'(done), 0);
        check_val("start_best_dist", 64'(best_dist), 64'(ACC_MAX));
    endtask

    task automatic end_check(input string tag);
        int bi = 0;
        for (int i = 1; i < dists.size(); i++)
            if (dists[i] < dists[bi]) bi = i;
        @(negedge clk);
        check_val({tag, "_best_dist"}, 64'(best_dist), 64'(dists[bi]));
        check_val({tag, "_best_idx"}, 64'(best_idx), 64'(bi % 256));
        check_val({tag, "_best_label"}, 64'(best_label), 64'(lbls[bi]));
        check_val({tag, "_done"}, 64'(done), 1);
        check_val({tag, "_busy"}, 64'(busy), 0);
        check_val({tag, "_pending"}, 64'(exp_q.size()), 0);
        check_val({tag, "_idx_ovf"}, 64'(idx_ovf), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 0);
        check_val("rst_best_dist", 64'(best_dist), 64'(ACC_MAX));
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_dist_valid", 64'(dist_valid), 0);
        check_val("rst_dist_sum", 64'(dist_sum), 0);
        check_val("rst_best_idx", 64'(best_idx), 0);
        check_val("rst_best_label", 64'(best_label), 0);
        check_val("rst_done", 64'(done), 0);
        check_val("rst_idx_ovf", 64'(idx_ovf), 0);

        // Beats while idle are ignored.
        drive(1, 5, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        check_val("idle_ignored_busy", 64'(busy), 0);

        // Basic: three samples of constant features 1, 2, 3.
        do_start(0);
        for (int s = 0; s < 3; s++) send_sample(4, s + 1, s + 1, (s == 2) ? 1 : 0, 0);
        end_check("basic");
        check_val("basic_small_ovf", 64'(s_idx_ovf), 0);

        // Completed search holds its outputs and ignores further beats.
        drive(1, 1, 1, 1, 3);
        drive(0, 0, 0, 0, 0);
        end_check("hold");
        check_val("hold_dist_sum", 64'(dist_sum), 12);

        // Ties keep the earlier sample: 50, 20, 20, 30.
        do_start(0);
        send_sample(2, 25, 0, 0, 0);
        send_sample(2, 10, 2, 0, 0);
        send_sample(2, 10, 3, 0, 0);
        send_sample(2, 15, 1, 1, 0);
        end_check("tie");

        // Saturation: 33 full-scale beats exceed the accumulator range.
        do_start(0);
        send_sample(33, 65025, 2, 0, 0);
        send_sample(1, 3, 1, 1, 0);
        end_check("sat");

        // Stall gaps between beats.
        do_start(0);
        send_sample(4, -1, 1, 0, 60);
        send_sample(4, -1, 2, 0, 60);
        send_sample(1, -1, 3, 1, 60);
        end_check("stall");

        // Abort a partial sample, restart with a coincident beat that must be dropped.
        do_start(0);
        drive(1, 1000, 0, 0, 0);
        drive(1, 1000, 0, 0, 0);
        do_start(1);
        send_sample(4, 1, 1, 0, 0);
        send_sample(4, 0, 2, 0, 0);
        send_sample(4, 2, 3, 1, 0);
        end_check("abort");

        // Randomized searches, small values to provoke ties.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(1, 8));
            do_start(0);
            for (int s = 0; s < n; s++)
                send_sample(int'($urandom_range(1, 6)),
                            ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)), (s == n - 1) ? 1 : 0, 30);
            end_check("rand");
        end

        // Index overflow on the 2-bit index copy.
        do_start(0);
        for (int s = 0; s < 5; s++) send_sample(1, -1, int'($urandom_range(0, 3)), (s == 4) ? 1 : 0, 0);
        end_check("ovf");
        check_val("ovf_small", 64'(s_idx_ovf), 1);

        // Reset mid-search.
        do_start(0);
        send_sample(2, 3, 1, 0, 0);
        drive(1, 4, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_best_dist", 64'(best_dist), 64'(ACC_MAX));
        check_val("midrst_busy", 64'(busy), 0);
        check_val("midrst_dist_sum", 64'(dist_sum), 0);
        check_val("midrst_best_idx", 64'(best_idx), 0);
        check_val("midrst_small_ovf", 64'(s_idx_ovf), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 9, 1, 1, 2);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_val("postrst_done", 64'(done), 0);
        check_val("postrst_busy", 64'(busy), 0);
        check_val("postrst_best_dist", 64'(best_dist), 64'(ACC_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
